// File: rtl/scene_ctrl.sv
// -----------------------------------------------------------------------------
// scene_ctrl
//
// Top-level scene sequencer for the game display. Tracks which renderer is
// on screen (start screen, game, game-over), runs a fade-to-black /
// fade-from-black transition between the start screen and the game, and
// scales the selected renderer's RGB444 pixel by the current brightness.
//
// Ports
//   clk            system clock, rising-edge active
//   rst            asynchronous reset, active low
//   frame_tick     one-cycle pulse at the start of each vertical blank
//   mouse_left     left button level, already synchronous to clk
//   mouse_in_start high while the cursor is over the start button
//   game_over      one-cycle pulse from the game logic
//   pixel_start    RGB444 pixel from the start-screen renderer
//   pixel_game     RGB444 pixel from the game renderer
//   pixel_over     RGB444 pixel from the game-over renderer
//   pixel          registered, brightness-scaled RGB444 pixel to VGA
//   scene          active renderer: 0 = start, 1 = game, 2 = over
//   game_en        high while the game logic may advance
//   game_rst       one-cycle pulse clearing the game state
//
// Parameter
//   STEP_FRAMES    frame_tick pulses per brightness step (1..15)
// -----------------------------------------------------------------------------
module scene_ctrl #(
    parameter int STEP_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        mouse_left,
    input  logic        mouse_in_start,
    input  logic        game_over,
    input  logic [11:0] pixel_start,
    input  logic [11:0] pixel_game,
    input  logic [11:0] pixel_over,
    output logic [11:0] pixel,
    output logic [1:0]  scene,
    output logic        game_en,
    output logic        game_rst
);

    typedef enum logic [2:0] {
        S_START,
        S_FADE_OUT,
        S_FADE_IN,
        S_GAME,
        S_OVER
    } state_t;

    // Frame counter value on which the next tick completes a brightness step.
    localparam logic [3:0] STEP_LAST = 4'(STEP_FRAMES - 1);

    state_t      state;
    logic [3:0]  level;
    logic [3:0]  fcnt;
    logic        mouse_prev;

    logic        click;
    logic        step_hit;
    logic [11:0] src_p0;

    // Scale one 4-bit channel by (level+1)/16; level 15 is unity, level 0 is black.
    function automatic logic [3:0] scale_channel(input logic [3:0] c, input logic [3:0] lvl);
        logic [7:0] prod;
        prod = {4'd0, c} * ({4'd0, lvl} + 8'd1);
        return 4'(prod >> 4);
    endfunction

    function automatic logic [1:0] scene_code(input state_t s);
        logic [1:0] code;
        case (s)
            S_FADE_IN, S_GAME: code = 2'd1;
            S_OVER:            code = 2'd2;
            default:           code = 2'd0;
        endcase
        return code;
    endfunction

    assign click    = mouse_left & ~mouse_prev;
    assign step_hit = frame_tick && (fcnt == STEP_LAST);

    // Scene FSM. scene/game_en follow the state register one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_START;
            level      <= 4'd15;
            fcnt       <= 4'd0;
            mouse_prev <= 1'b0;
            scene      <= 2'd0;
            game_en    <= 1'b0;
            game_rst   <= 1'b0;
        end else begin
            mouse_prev <= mouse_left;
            scene      <= scene_code(state);
            game_en    <= (state == S_GAME);
            game_rst   <= 1'b0;

            case (state)
                S_START: begin
                    // A click wins over any simultaneous tick; ticks are unused here.
                    if (click && mouse_in_start) begin
                        state <= S_FADE_OUT;
                        fcnt  <= 4'd0;
                        level <= 4'd15;
                    end
                end
                S_FADE_OUT: begin
                    if (frame_tick) begin
                        if (step_hit) begin
                            fcnt <= 4'd0;
                            if (level == 4'd0) begin
                                // Fully black: swap to the game scene and clear it.
                                state    <= S_FADE_IN;
                                game_rst <= 1'b1;
                            end else begin
                                level <= level - 4'd1;
                            end
                        end else begin
                            fcnt <= fcnt + 4'd1;
                        end
                    end
                end
                S_FADE_IN: begin
                    if (frame_tick) begin
                        if (step_hit) begin
                            fcnt <= 4'd0;
                            if (level == 4'd15) begin
                                state <= S_GAME;
                            end else begin
                                level <= level + 4'd1;
                            end
                        end else begin
                            fcnt <= fcnt + 4'd1;
                        end
                    end
                end
                S_GAME: begin
                    if (game_over) begin
                        state <= S_OVER;
                    end
                end
                S_OVER: begin
                    if (click) begin
                        state <= S_START;
                    end
                end
                default: begin
                    state <= S_START;
                    level <= 4'd15;
                    fcnt  <= 4'd0;
                end
            endcase
        end
    end

    // Stage p0: source select by the registered scene.
    always_comb begin
        src_p0 = 12'h000;
        case (scene)
            2'd0:    src_p0 = pixel_start;
            2'd1:    src_p0 = pixel_game;
            2'd2:    src_p0 = pixel_over;
            default: src_p0 = 12'h000;
        endcase
    end

    // Stage p1: brightness scaling into the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel <= 12'h000;
        end else begin
            pixel <= {scale_channel(src_p0[11:8], level),
                      scale_channel(src_p0[7:4],  level),
                      scale_channel(src_p0[3:0],  level)};
        end
    end

endmodule

// File: tb/tb_scene_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scene_ctrl
//
// Self-checking bench for scene_ctrl (STEP_FRAMES = 2). A behavioural model
// (integer scene phase, brightness and tick count) runs alongside the DUT and
// every cycle's outputs are compared with it; a vector table and a few
// hand-written sequences add fixed expected values for the key scenarios,
// followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_scene_ctrl;

    localparam int STEP = 2;

    localparam int M_START    = 0;
    localparam int M_FADE_OUT = 1;
    localparam int M_FADE_IN  = 2;
    localparam int M_GAME     = 3;
    localparam int M_OVER     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        mouse_left = 1'b0;
    logic        mouse_in_start = 1'b0;
    logic        game_over = 1'b0;
    logic [11:0] pixel_start = 12'h000;
    logic [11:0] pixel_game = 12'h000;
    logic [11:0] pixel_over = 12'h000;
    logic [11:0] pixel;
    logic [1:0]  scene;
    logic        game_en;
    logic        game_rst;

    int n_cmp = 0;
    int n_bad = 0;
    int grst_count = 0;

    // Reference model state
    int m_mode;
    int m_lvl;
    int m_ticks;
    bit m_prev;
    int e_scene;
    int e_en;
    int e_grst;
    int e_pix;

    scene_ctrl #(.STEP_FRAMES(STEP)) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .mouse_left     (mouse_left),
        .mouse_in_start (mouse_in_start),
        .game_over      (game_over),
        .pixel_start    (pixel_start),
        .pixel_game     (pixel_game),
        .pixel_over     (pixel_over),
        .pixel          (pixel),
        .scene          (scene),
        .game_en        (game_en),
        .game_rst       (game_rst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int scale12(input int p, input int l);
        int r;
        r = 0;
        for (int ch = 0; ch < 3; ch++) begin
            int c;
            c = (p >> (4 * ch)) & 15;
            r = r | (((c * (l + 1)) / 16) << (4 * ch));
        end
        return r;
    endfunction

    function automatic int scene_of(input int mode);
        if (mode == M_START || mode == M_FADE_OUT) return 0;
        if (mode == M_OVER) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        m_mode  = M_START;
        m_lvl   = 15;
        m_ticks = 0;
        m_prev  = 1'b0;
        e_scene = 0;
        e_en    = 0;
        e_grst  = 0;
        e_pix   = 0;
    endtask

    // One clock of the scene rules, using the inputs present at the edge.
    task automatic model_step();
        bit click;
        int src;
        int n_scene, n_en, n_grst, n_pix;
        click   = mouse_left && !m_prev;
        n_scene = scene_of(m_mode);
        n_en    = (m_mode == M_GAME) ? 1 : 0;
        n_grst  = 0;
        src     = (e_scene == 0) ? int'(pixel_start) :
                  (e_scene == 1) ? int'(pixel_game)  :
                  (e_scene == 2) ? int'(pixel_over)  : 0;
        n_pix   = scale12(src, m_lvl);
        case (m_mode)
            M_START: if (click && mouse_in_start) begin
                m_mode = M_FADE_OUT; m_ticks = 0; m_lvl = 15;
            end
            M_FADE_OUT: if (frame_tick) begin
                m_ticks++;
                if (m_ticks == STEP) begin
                    m_ticks = 0;
                    if (m_lvl == 0) begin m_mode = M_FADE_IN; n_grst = 1; end
                    else m_lvl--;
                end
            end
            M_FADE_IN: if (frame_tick) begin
                m_ticks++;
                if (m_ticks == STEP) begin
                    m_ticks = 0;
                    if (m_lvl == 15) m_mode = M_GAME;
                    else m_lvl++;
                end
            end
            M_GAME: if (game_over) m_mode = M_OVER;
            default: if (click) m_mode = M_START;
        endcase
        m_prev  = mouse_left;
        e_scene = n_scene;
        e_en    = n_en;
        e_grst  = n_grst;
        e_pix   = n_pix;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        if (game_rst) grst_count++;
        chk("model_scene", int'(scene), e_scene);
        chk("model_game_en", int'(game_en), e_en);
        chk("model_game_rst", int'(game_rst), e_grst);
        chk("model_pixel", int'(pixel), e_pix);
    endtask

    task automatic tick_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_pixel", int'(pixel), 0);
        chk("rst_scene", int'(scene), 0);
        chk("rst_game_en", int'(game_en), 0);
        chk("rst_game_rst", int'(game_rst), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct packed {
        logic        ml;
        logic        in_btn;
        logic        tick;
        logic        go;
        logic [11:0] ps;
        logic [1:0]  scene;
        logic        en;
        logic        grst;
        logic [11:0] pix;
    } vec_t;

    vec_t vecs [0:9];

    initial begin
        // Rows start from reset: START, level 15.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'hABC, 2'd0, 1'b0, 1'b0, 12'hABC};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'hFFF, 2'd0, 1'b0, 1'b0, 12'hFFF};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h123, 2'd0, 1'b0, 1'b0, 12'h123};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h0F0, 2'd0, 1'b0, 1'b0, 12'h0F0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 12'hFFF, 2'd0, 1'b0, 1'b0, 12'hFFF};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 12'hFFF, 2'd0, 1'b0, 1'b0, 12'hFFF};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF, 2'd0, 1'b0, 1'b0, 12'hFFF};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 12'hFFF, 2'd0, 1'b0, 1'b0, 12'hFFF};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF, 2'd0, 1'b0, 1'b0, 12'hEEE};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 12'hFFF, 2'd0, 1'b0, 1'b0, 12'hEEE};

        model_reset();
        pixel_game = 12'h123;
        pixel_over = 12'h456;
        do_reset();

        // Vector table: start screen, ignored events, click and first fade step.
        for (int i = 0; i < 10; i++) begin
            mouse_left     = vecs[i].ml;
            mouse_in_start = vecs[i].in_btn;
            frame_tick     = vecs[i].tick;
            game_over      = vecs[i].go;
            pixel_start    = vecs[i].ps;
            step();
            chk($sformatf("vec%0d_scene", i), int'(scene), int'(vecs[i].scene));
            chk($sformatf("vec%0d_game_en", i), int'(game_en), int'(vecs[i].en));
            chk($sformatf("vec%0d_game_rst", i), int'(game_rst), int'(vecs[i].grst));
            chk($sformatf("vec%0d_pixel", i), int'(pixel), int'(vecs[i].pix));
        end
        mouse_left = 1'b0; frame_tick = 1'b0; game_over = 1'b0;

        // Full fade out, swap to game with one game_rst pulse.
        do_reset();
        pixel_start = 12'hFFF; pixel_game = 12'hFFF; pixel_over = 12'hABC;
        mouse_in_start = 1'b1;
        grst_count = 0;
        mouse_left = 1'b1; step();
        mouse_left = 1'b0; step();
        tick_pulses(30);
        chk("fade_out_black_pixel", int'(pixel), 12'h000);
        chk("fade_out_black_scene", int'(scene), 0);
        tick_pulses(1);
        frame_tick = 1'b1; step();
        chk("fade_in_entry_game_rst", int'(game_rst), 1);
        frame_tick = 1'b0; step();
        chk("fade_in_game_rst_cleared", int'(game_rst), 0);
        chk("fade_in_scene", int'(scene), 1);
        chk("game_rst_pulse_count", grst_count, 1);

        // Fade in to level 7, then on to the game.
        pixel_game = 12'hF83;
        tick_pulses(14);
        chk("level7_pixel", int'(pixel), 12'h741);
        tick_pulses(16);
        frame_tick = 1'b1; step();
        step();
        chk("game_entry_en_low", int'(game_en), 0);
        frame_tick = 1'b0; step();
        chk("game_en_rise", int'(game_en), 1);

        // Click in game ignored; game_over moves to the over screen.
        mouse_in_start = 1'b1;
        mouse_left = 1'b1; step();
        mouse_left = 1'b0; step();
        chk("game_click_ignored_en", int'(game_en), 1);
        chk("game_pixel", int'(pixel), 12'hF83);
        game_over = 1'b1; step();
        game_over = 1'b0; step();
        chk("over_scene", int'(scene), 2);
        chk("over_game_en", int'(game_en), 0);
        step();
        chk("over_pixel", int'(pixel), 12'hABC);
        mouse_in_start = 1'b0;
        mouse_left = 1'b1; step();
        mouse_left = 1'b0; step();
        chk("back_to_start_scene", int'(scene), 0);
        step();
        chk("back_to_start_pixel", int'(pixel), 12'hFFF);

        // Asynchronous reset mid fade-in, mouse held through reset release.
        do_reset();
        pixel_game = 12'hFFF;
        mouse_in_start = 1'b1;
        mouse_left = 1'b1; step();
        mouse_left = 1'b0; step();
        tick_pulses(32);
        tick_pulses(10);
        chk("fade_in_level5_pixel", int'(pixel), 12'h555);
        mouse_left = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst_pixel", int'(pixel), 0);
        chk("async_rst_scene", int'(scene), 0);
        chk("async_rst_game_en", int'(game_en), 0);
        chk("async_rst_game_rst", int'(game_rst), 0);
        @(posedge clk); #1;
        chk("held_rst_pixel", int'(pixel), 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        mouse_left = 1'b0; step();
        tick_pulses(2);
        chk("resume_fade_pixel", int'(pixel), 12'hEEE);
        chk("resume_fade_scene", int'(scene), 0);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            frame_tick     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) mouse_left = ~mouse_left;
            mouse_in_start = 1'($urandom_range(0, 1));
            game_over      = ($urandom_range(0, 15) == 0);
            pixel_start    = 12'($urandom);
            pixel_game     = 12'($urandom);
            pixel_over     = 12'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
